phase_uncomp: RTL and testbench

PHASE_UNCOMP -- requirements
Module: phase_uncomp

---
 rtl/pfb_pkg.sv | 26 ++
 rtl/sdp_ram.sv | 30 +++
 rtl/phase_uncomp.sv | 98 +++++++++
 tb/tb_phase_uncomp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_pkg.sv
// Shared definitions for the polyphase filter bank
// phase compensation and uncompensation stages.
package pfb_pkg;

  localparam int PFB_M     = 8;
  localparam int PFB_D     = 6;
  localparam int PFB_WIDTH = 16;

  typedef enum logic [1:0] {
    PRIME,
    FILLA,
    FILLB
  } pfb_state_t;

  // Modular add by compare-subtract; a, b < m.
  function automatic int wrap_add(
    input int a,
    input int b,
    input int m
  );
    int t;
    t = a + b;
    return (t >= m) ? t - m : t;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one
// registered read port that holds its last value.
module sdp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, cleared by reset, held when idle
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/phase_uncomp.sv
// Undoes the per-frame circular shift applied on the
// analysis side using a ping-pong frame buffer.
module phase_uncomp
  import pfb_pkg::*;
#(
  parameter int M     = PFB_M,
  parameter int D     = PFB_D,
  parameter int WIDTH = PFB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sof
);

  localparam int AW = $clog2(2 * M);
  localparam logic [AW-1:0] MOFF = AW'(M);
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  pfb_state_t    state;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;
  logic [AW-1:0] s;
  logic [AW-1:0] s_nxt;
  logic [AW-1:0] r_nxt;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          acc;
  logic          rd;
  logic          wlast;

  // accept/read qualifiers and bank-relative addresses
  always_comb begin
    acc   = din_valid & ~rst;
    rd    = acc & (state != PRIME);
    wlast = (widx == LAST);
    s_nxt = AW'(wrap_add(int'(s), M - D, M));
    r_nxt = AW'(wrap_add(int'(ridx), 1, M));
    waddr = (state == FILLB) ? widx + MOFF : widx;
    raddr = (state == FILLA) ? ridx + MOFF : ridx;
  end

  // frame FSM, write/read indices and shift offset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIME;
      widx       <= '0;
      ridx       <= '0;
      s          <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
    end else begin
      dout_valid <= rd;
      dout_sof   <= rd & (widx == '0);
      if (acc) begin
        widx <= wlast ? '0 : widx + 1'b1;
        if (rd) ridx <= r_nxt;
        if (wlast) begin
          unique case (state)
            PRIME: begin
              state <= FILLB;
              ridx  <= s;
            end
            FILLB: begin
              state <= FILLA;
              s     <= s_nxt;
              ridx  <= s_nxt;
            end
            FILLA: begin
              state <= FILLB;
              s     <= s_nxt;
              ridx  <= s_nxt;
            end
            default: state <= PRIME;
          endcase
        end
      end
    end
  end

  sdp_ram #(
    .DEPTH (2 * M),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (acc),
    .waddr (waddr),
    .wdata (din),
    .re    (rd),
    .raddr (raddr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_phase_uncomp.sv
// Bench for phase_uncomp: M=8/D=6 and M=4/D=3
// instances share one input stream.
module tb_phase_uncomp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [15:0] dout8, dout4;
  logic        dv8, dv4, sof8, sof4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  phase_uncomp #(.M(8), .D(6), .WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .din(din),
    .din_valid(din_valid), .dout(dout8),
    .dout_valid(dv8), .dout_sof(sof8)
  );

  phase_uncomp #(.M(4), .D(3), .WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .din(din),
    .din_valid(din_valid), .dout(dout4),
    .dout_valid(dv4), .dout_sof(sof4)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mbuf [2][8];
  int          mw   [2];
  int          mfr  [2];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [15:0] last [2];
  int          nval [2];
  int          nsof [2];

  task automatic model_edge(
    input  int          id,
    input  int          m,
    input  int          dd,
    input  logic        a,
    input  logic        r,
    input  logic [15:0] d,
    output logic        ev,
    output logic [16:0] ex
  );
    int s;
    logic [16:0] e;
    ev = 1'b0;
    ex = '0;
    if (r) begin
      mw[id]  = 0;
      mfr[id] = 0;
      if (id == 0) q0.delete();
      else q1.delete();
      return;
    end
    if (!a) return;
    if (mfr[id] >= 1) begin
      ev = 1'b1;
      if (id == 0 && q0.size() > 0) ex = q0.pop_front();
      if (id == 1 && q1.size() > 0) ex = q1.pop_front();
    end
    mbuf[id][mw[id]] = d;
    mw[id]++;
    if (mw[id] == m) begin
      s = (mfr[id] * (m - dd)) % m;
      for (int n = 0; n < m; n++) begin
        e = {n == 0, mbuf[id][(n + s) % m]};
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      mfr[id]++;
      mw[id] = 0;
    end
  endtask

  task automatic mon_check(
    input int          id,
    input logic        r,
    input logic        ev,
    input logic [16:0] ex,
    input logic        v,
    input logic [15:0] dq,
    input logic        sf
  );
    if (r) begin
      chk($sformatf("rst_valid%0d", id), v, 0);
      chk($sformatf("rst_dout%0d", id), dq, 0);
      chk($sformatf("rst_sof%0d", id), sf, 0);
    end else begin
      chk($sformatf("valid%0d", id), v, ev);
      if (ev) begin
        chk($sformatf("dout%0d", id), dq, ex[15:0]);
        chk($sformatf("sof%0d", id), sf, ex[16]);
        nval[id]++;
        if (sf) nsof[id]++;
      end else begin
        chk($sformatf("hold%0d", id), dq, last[id]);
        chk($sformatf("sof_idle%0d", id), sf, 0);
      end
    end
    last[id] = dq;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mw[i] = 0; mfr[i] = 0; last[i] = '0;
      nval[i] = 0; nsof[i] = 0;
    end
  end

  // monitor for the M=8 instance
  always begin
    logic        a, r, ev;
    logic [15:0] d;
    logic [16:0] ex;
    @(posedge clk);
    a = din_valid; r = rst; d = din;
    model_edge(0, 8, 6, a, r, d, ev, ex);
    #1;
    mon_check(0, r, ev, ex, dv8, dout8, sof8);
  end

  // monitor for the M=4 instance
  always begin
    logic        a, r, ev;
    logic [15:0] d;
    logic [16:0] ex;
    @(posedge clk);
    a = din_valid; r = rst; d = din;
    model_edge(1, 4, 3, a, r, d, ev, ex);
    #1;
    mon_check(1, r, ev, ex, dv4, dout4, sof4);
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] din;
    logic        ev;
    logic [15:0] edout;
    logic        esof;
  } vec_t;

  vec_t tab [40];
  int ef [4][8] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7},
    '{10, 11, 12, 13, 14, 15, 8, 9},
    '{20, 21, 22, 23, 16, 17, 18, 19},
    '{30, 31, 24, 25, 26, 27, 28, 29}
  };

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b1;
    din = 16'hdead;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
  endtask

  initial begin
    int v0, v1, acc;
    for (int i = 0; i < 40; i++) begin
      tab[i].din   = 16'(i);
      tab[i].ev    = (i >= 8);
      tab[i].edout = (i >= 8) ? 16'(ef[i/8-1][i%8]) : '0;
      tab[i].esof  = (i >= 8) && (i % 8 == 0);
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_dout", dout8, 0);
    chk("reset_valid", dv8, 0);
    chk("reset_sof", sof8, 0);

    // continuous ramp of five frames
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      din = tab[i].din;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("tab_valid[%0d]", i), dv8, tab[i].ev);
      if (tab[i].ev) begin
        chk($sformatf("tab_dout[%0d]", i),
            dout8, tab[i].edout);
        chk($sformatf("tab_sof[%0d]", i),
            sof8, tab[i].esof);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;

    // same stream with din_valid toggling 1,0
    do_reset();
    v0 = nval[0];
    v1 = nval[1];
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      din_valid = (i % 2 == 0);
      din = 16'(i / 2);
    end
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    chk("toggle_count8", nval[0] - v0, 32);
    chk("toggle_count4", nval[1] - v1, 36);

    // reset after 5 samples of frame 2
    do_reset();
    for (int i = 0; i < 21; i++) push(16'(i));
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b1;
    din = 16'hbeef;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    v0 = nval[0];
    for (int i = 0; i < 8; i++) push(16'(200 + i));
    @(negedge clk);
    din_valid = 1'b0;
    chk("no_stale8", nval[0] - v0, 0);
    for (int i = 8; i < 24; i++) push(16'(200 + i));
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    chk("restart_count8", nval[0] - v0, 16);

    // randomized din_valid over 100 frames
    do_reset();
    nval[0] = 0; nsof[0] = 0;
    nval[1] = 0; nsof[1] = 0;
    acc = 0;
    while (acc < 800) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);
      if (din_valid) acc++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    chk("rand_valid8", nval[0], 792);
    chk("rand_sof8", nsof[0], 99);
    chk("rand_valid4", nval[1], 796);
    chk("rand_sof4", nsof[1], 199);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
